hop_chain_array: RTL and testbench

Parametrised multi-lane hop pipeline: `LANES` independent shift chains, each `DEPTH` stages of `WIDTH` bits with a per-stage valid bit. It extends the fixed four-lane, six-flop hop benchmark with several features:
- runtime output tap selection;
- per-lane stall and synchronous clear;
- per-lane occupancy counting.

It sits in the hop micro-benchmark family as the configurable timing-path generator for placement and routing studies.

---
 rtl/hop_chain_array_if.sv | 29 ++
 rtl/hop_chain_array.sv | 73 +++++++
 tb/tb_hop_chain_array.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hop_chain_array_if.sv
// rtl/hop_chain_array_if.sv - lane-vector bus for the hop chain array
interface hop_chain_array_if #(
    parameter int LANES = 4,
    parameter int DEPTH = 6,
    parameter int WIDTH = 1
);
    localparam int TW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [LANES*WIDTH-1:0] start;
    logic [LANES-1:0]       start_vld;
    logic [LANES-1:0]       hold;
    logic [LANES-1:0]       clr;
    logic [LANES*TW-1:0]    tap;
    logic [LANES*WIDTH-1:0] out;
    logic [LANES-1:0]       out_vld;
    logic [LANES*CW-1:0]    occ;
    logic [LANES-1:0]       busy;

    modport master (
        output start, start_vld, hold, clr, tap,
        input  out, out_vld, occ, busy
    );

    modport slave (
        input  start, start_vld, hold, clr, tap,
        output out, out_vld, occ, busy
    );
endinterface

// File: rtl/hop_chain_array.sv
// rtl/hop_chain_array.sv - multi-lane hop shift chains with tap select, stall, clear and occupancy
module hop_chain_array #(
    parameter int LANES = 4,
    parameter int DEPTH = 6,
    parameter int WIDTH = 1
) (
    input  logic               clock0,
    input  logic               rst1_n,
    hop_chain_array_if.slave   bus
);
    localparam int TW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Index 0 is stage 1 (newest), index DEPTH-1 is the exit stage.
        logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
        logic [DEPTH-1:0]            v_q, v_d;
        logic [CW-1:0]               occ_q, occ_d;
        logic [WIDTH-1:0]            in_data;
        logic [TW-1:0]               tap_l;
        logic [WIDTH-1:0]            out_data;
        logic                        out_v;

        assign in_data = bus.start[l*WIDTH +: WIDTH];
        assign tap_l   = bus.tap[l*TW +: TW];

        // Next state: clear beats hold beats shift; invalid slots are loaded with zero data.
        always_comb begin
            s_d   = s_q;
            v_d   = v_q;
            occ_d = occ_q;
            if (bus.clr[l]) begin
                s_d   = '0;
                v_d   = '0;
                occ_d = '0;
            end else if (!bus.hold[l]) begin
                s_d   = {s_q[DEPTH-2:0], (bus.start_vld[l] ? in_data : {WIDTH{1'b0}})};
                v_d   = {v_q[DEPTH-2:0], bus.start_vld[l]};
                occ_d = occ_q + CW'(bus.start_vld[l]) - CW'(v_q[DEPTH-1]);
            end
        end

        // Stage, valid and occupancy registers with asynchronous clear.
        always_ff @(posedge clock0 or negedge rst1_n) begin
            if (!rst1_n) begin
                s_q   <= '0;
                v_q   <= '0;
                occ_q <= '0;
            end else begin
                s_q   <= s_d;
                v_q   <= v_d;
                occ_q <= occ_d;
            end
        end

        // Tap mux over registered stages; out-of-range taps clamp to the exit stage.
        always_comb begin
            out_data = '0;
            out_v    = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if ((int'(tap_l) == k) || ((k == DEPTH - 1) && (int'(tap_l) > k))) begin
                    out_data = s_q[k];
                    out_v    = v_q[k];
                end
            end
        end

        assign bus.out[l*WIDTH +: WIDTH] = out_data;
        assign bus.out_vld[l]            = out_v;
        assign bus.occ[l*CW +: CW]       = occ_q;
        assign bus.busy[l]               = |occ_q;
    end
endmodule

// File: tb/tb_hop_chain_array.sv
// tb/tb_hop_chain_array.sv - randomized and directed checks of hop_chain_array against a queue model
module tb_hop_chain_array;
    localparam int LANES = 4;
    localparam int DEPTH = 6;
    localparam int WIDTH = 8;
    localparam int TW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hop_chain_array_if #(.LANES(LANES), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    hop_chain_array #(.LANES(LANES), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock0 (clk),
        .rst1_n (rst_n),
        .bus    (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit model_ready = 1'b0;

    // Model: each lane is a queue of DEPTH slots, front = stage 1.
    logic [WIDTH-1:0] mq [LANES][$];
    bit               mv [LANES][$];

    task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane %0d: got %0h expected %0h at %0t", name, lane, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] out_of(int l);
        return bus.out[l*WIDTH +: WIDTH];
    endfunction

    function automatic logic [CW-1:0] occ_of(int l);
        return bus.occ[l*CW +: CW];
    endfunction

    function automatic int tap_of(int l);
        return int'(bus.tap[l*TW +: TW]);
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            mq[l].delete();
            mv[l].delete();
            for (int k = 0; k < DEPTH; k++) begin
                mq[l].push_back('0);
                mv[l].push_back(1'b0);
            end
        end
    endtask

    task automatic model_step();
        for (int l = 0; l < LANES; l++) begin
            if (bus.clr[l]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mq[l][k] = '0;
                    mv[l][k] = 1'b0;
                end
            end else if (!bus.hold[l]) begin
                mq[l].push_front(bus.start_vld[l] ? bus.start[l*WIDTH +: WIDTH] : '0);
                mv[l].push_front(bus.start_vld[l]);
                void'(mq[l].pop_back());
                void'(mv[l].pop_back());
            end
        end
    endtask

    function automatic int model_occ(int l);
        int c = 0;
        foreach (mv[l][k]) c += int'(mv[l][k]);
        return c;
    endfunction

    // Compare every lane's outputs against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ready) begin
            for (int l = 0; l < LANES; l++) begin
                int idx;
                idx = (tap_of(l) >= DEPTH) ? DEPTH - 1 : tap_of(l);
                chk("out",     l, 64'(out_of(l)),         64'(mq[l][idx]));
                chk("out_vld", l, 64'(bus.out_vld[l]),    64'(mv[l][idx]));
                chk("occ",     l, 64'(occ_of(l)),         64'(model_occ(l)));
                chk("busy",    l, 64'(bus.busy[l]),       64'(model_occ(l) != 0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #2;
    endtask

    task automatic idle();
        bus.start     = '0;
        bus.start_vld = '0;
        bus.hold      = '0;
        bus.clr       = '0;
    endtask

    task automatic set_tap(input int l, input int t);
        bus.tap[l*TW +: TW] = TW'(t);
    endtask

    task automatic drive(input int l, input int d, input bit vld);
        bus.start[l*WIDTH +: WIDTH] = WIDTH'(d);
        bus.start_vld[l]            = vld;
    endtask

    initial begin
        idle();
        bus.tap = '0;
        model_reset();
        model_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_occ",  0, 64'(bus.occ),     64'd0);
        chk("rst_vld",  0, 64'(bus.out_vld), 64'd0);
        chk("rst_busy", 0, 64'(bus.busy),    64'd0);
        chk("rst_out",  0, 64'(bus.out),     64'd0);
        rst_n = 1'b1;

        // Single pulse on lane 0, tap 5
        for (int l = 0; l < LANES; l++) set_tap(l, 5);
        drive(0, 1, 1'b1);
        tick();
        idle();
        chk("pulse_occ1", 0, 64'(occ_of(0)),      64'd1);
        chk("pulse_vld1", 0, 64'(bus.out_vld[0]), 64'd0);
        for (int e = 2; e <= 7; e++) begin
            tick();
            chk("pulse_vld", 0, 64'(bus.out_vld[0]), 64'(e == 6));
            chk("pulse_out", 0, 64'(out_of(0)),      64'((e == 6) ? 1 : 0));
            chk("pulse_occ", 0, 64'(occ_of(0)),      64'((e <= 6) ? 1 : 0));
        end
        chk("pulse_others", 0, 64'(bus.busy[LANES-1:1]), 64'd0);

        // Tap sweep on lane 1
        drive(1, 8'h11, 1'b1); tick();
        drive(1, 8'h22, 1'b1); tick();
        drive(1, 8'h33, 1'b1); tick();
        idle();
        set_tap(1, 0); #1;
        chk("sweep_t0",  1, 64'(out_of(1)), 64'h33);
        set_tap(1, 2); #1;
        chk("sweep_t2",  1, 64'(out_of(1)), 64'h11);
        set_tap(1, 3); #1;
        chk("sweep_t3v", 1, 64'(bus.out_vld[1]), 64'd0);
        set_tap(1, 7); #1;
        chk("sweep_t7a", 1, 64'(out_of(1)), 64'h00);
        repeat (3) tick();
        chk("sweep_t7",  1, 64'(out_of(1)), 64'h11);
        chk("sweep_t7v", 1, 64'(bus.out_vld[1]), 64'd1);
        set_tap(1, 4); #1;
        chk("sweep_t4",  1, 64'(out_of(1)), 64'h22);
        repeat (3) tick();

        // Hold on lane 2
        set_tap(2, 0);
        drive(2, 8'hA5, 1'b1);
        tick();
        chk("hold_occ0", 2, 64'(occ_of(2)), 64'd1);
        bus.hold[2] = 1'b1;
        drive(2, 8'h5A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_occ", 2, 64'(occ_of(2)), 64'd1);
            chk("hold_out", 2, 64'(out_of(2)), 64'hA5);
        end
        idle();
        set_tap(2, 5);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("hold_ovld", 2, 64'(bus.out_vld[2]), 64'(i == 5));
            chk("hold_odat", 2, 64'(out_of(2)),      64'((i == 5) ? 8'hA5 : 8'h00));
            chk("hold_occ2", 2, 64'(occ_of(2)),      64'((i < 6) ? 1 : 0));
        end

        // Continuous input on lane 3, tap 2
        set_tap(3, 2);
        for (int i = 0; i < 20; i++) begin
            drive(3, i + 1, 1'b1);
            tick();
            chk("full_occ",  3, 64'(occ_of(3)),      64'((i + 1 < DEPTH) ? i + 1 : DEPTH));
            chk("full_busy", 3, 64'(bus.busy[3]),    64'd1);
            chk("full_out",  3, 64'(out_of(3)),      64'((i >= 2) ? i - 1 : 0));
            chk("full_ovld", 3, 64'(bus.out_vld[3]), 64'(i >= 2));
        end
        idle();

        // Clear priority on a full lane 0
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 8'h40 + i, 1'b1);
            tick();
        end
        chk("clr_pre_occ", 0, 64'(occ_of(0)), 64'(DEPTH));
        bus.clr[0]  = 1'b1;
        bus.hold[0] = 1'b1;
        drive(0, 8'hFF, 1'b1);
        tick();
        chk("clr_occ", 0, 64'(occ_of(0)),      64'd0);
        chk("clr_vld", 0, 64'(bus.out_vld[0]), 64'd0);
        chk("clr_out", 0, 64'(out_of(0)),      64'd0);
        idle();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < LANES; l++) begin
                drive(l, int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
                bus.hold[l] = ($urandom_range(0, 5) == 0);
                bus.clr[l]  = ($urandom_range(0, 19) == 0);
                set_tap(l, int'($urandom_range(0, (1 << TW) - 1)));
            end
            tick();
        end
        idle();

        // Asynchronous reset with every lane busy
        for (int i = 0; i < 3; i++) begin
            for (int l = 0; l < LANES; l++) drive(l, 8'h10 * l + i, 1'b1);
            tick();
        end
        chk("ar_busy", 0, 64'(bus.busy), 64'(4'hF));
        idle();
        rst_n = 1'b0;
        #1;
        chk("ar_occ",  0, 64'(bus.occ),     64'd0);
        chk("ar_vld",  0, 64'(bus.out_vld), 64'd0);
        chk("ar_busy0",0, 64'(bus.busy),    64'd0);
        chk("ar_out",  0, 64'(bus.out),     64'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(0, 8'h77, 1'b1);
        set_tap(0, 0);
        tick();
        idle();
        chk("ar_resume_occ", 0, 64'(occ_of(0)), 64'd1);
        chk("ar_resume_out", 0, 64'(out_of(0)), 64'h77);
        repeat (8) tick();

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
